// File: rtl/mux_stream_arbiter.sv
// Round-robin burst arbiter for two valid/ready streams sharing a 2:1 select datapath.
// Whole bursts are granted, capped at MAX_BURST beats, and the chosen word is registered.
module mux_stream_arbiter #(
  parameter int array_size = 9,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [array_size-1:0] in1,
  input  logic                  in1_valid,
  input  logic                  in1_last,
  output logic                  in1_ready,
  input  logic [array_size-1:0] in2,
  input  logic                  in2_valid,
  input  logic                  in2_last,
  output logic                  in2_ready,
  output logic [array_size-1:0] out,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  sel
);

  localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic                    prio;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    can_load;
  logic                    take;
  logic                    take_last;
  logic [array_size-1:0]   take_data;

  // The output slot is free when empty or being drained this same cycle.
  assign can_load = !out_valid || out_ready;

  always_comb begin
    next_state = state;
    in1_ready  = 1'b0;
    in2_ready  = 1'b0;
    sel        = 1'b0;
    take       = 1'b0;
    take_last  = 1'b0;
    take_data  = '0;
    case (state)
      IDLE: begin
        if (in1_valid && (!in2_valid || !prio)) begin
          next_state = GRANT1;
        end else if (in2_valid) begin
          next_state = GRANT2;
        end
      end
      GRANT1: begin
        in1_ready = can_load;
        take      = in1_valid && can_load;
        take_data = in1;
        take_last = in1_last || (beat_cnt == LAST_BEAT);
        if (take && take_last) next_state = IDLE;
      end
      GRANT2: begin
        sel       = 1'b1;
        in2_ready = can_load;
        take      = in2_valid && can_load;
        take_data = in2;
        take_last = in2_last || (beat_cnt == LAST_BEAT);
        if (take && take_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      beat_cnt  <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= next_state;
      if (take) begin
        out       <= take_data;
        out_valid <= 1'b1;
        out_last  <= take_last;
        if (take_last) begin
          // Hand priority to the side that did not just finish a burst.
          beat_cnt <= '0;
          prio     <= (state == GRANT1);
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_stream_arbiter.sv
// Directed bench for mux_stream_arbiter: burst order, bubbles, forced release,
// backpressure and mid-burst reset, with hand-computed expected values.
module tb_mux_stream_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] in1, in2;
  logic       in1_valid, in1_last, in2_valid, in2_last;
  logic       in1_ready, in2_ready;
  logic [8:0] out_w;
  logic       out_valid, out_last, out_ready, sel;

  int checks   = 0;
  int failures = 0;

  mux_stream_arbiter #(.array_size(9), .MAX_BURST(16)) dut (
    .clk(clk), .reset(reset),
    .in1(in1), .in1_valid(in1_valid), .in1_last(in1_last), .in1_ready(in1_ready),
    .in2(in2), .in2_valid(in2_valid), .in2_last(in2_last), .in2_ready(in2_ready),
    .out(out_w), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .sel(sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [8:0] d, input logic v, input logic l);
    chk({tag, "_out"}, 16'(out_w), 16'(d));
    chk({tag, "_vld"}, 16'(out_valid), 16'(v));
    chk({tag, "_last"}, 16'(out_last), 16'(l));
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    in1 = '0; in1_valid = 1'b0; in1_last = 1'b0;
    in2 = '0; in2_valid = 1'b0; in2_last = 1'b0;
    tick(); tick();
    chk_out("rst", 9'h000, 1'b0, 1'b0);
    chk("rst_sel", 16'(sel), 16'd0);
    chk("rst_rdy1", 16'(in1_ready), 16'd0);
    chk("rst_rdy2", 16'(in2_ready), 16'd0);
    reset = 1'b0;

    // Test 1: in1 burst of 3, in2 idle
    in1_valid = 1'b1; in1 = 9'h0A1; #1;
    chk("t1_idle_rdy1", 16'(in1_ready), 16'd0);
    tick();
    chk("t1_g_sel", 16'(sel), 16'd0);
    chk("t1_g_rdy1", 16'(in1_ready), 16'd1);
    tick(); chk_out("t1_a1", 9'h0A1, 1'b1, 1'b0); chk("t1_a1_sel", 16'(sel), 16'd0);
    in1 = 9'h0A2;
    tick(); chk_out("t1_a2", 9'h0A2, 1'b1, 1'b0);
    in1 = 9'h1A3; in1_last = 1'b1;
    tick(); chk_out("t1_a3", 9'h1A3, 1'b1, 1'b1);
    in1_valid = 1'b0; in1_last = 1'b0; #1;
    chk("t1_idle_sel", 16'(sel), 16'd0);
    chk("t1_idle_rdy", 16'(in1_ready), 16'd0);
    in1_valid = 1'b1; in2_valid = 1'b1;
    tick(); chk("t1_drain_vld", 16'(out_valid), 16'd0);
    chk("t1_prio_sel", 16'(sel), 16'd1);
    chk("t1_prio_rdy2", 16'(in2_ready), 16'd1);
    in1_valid = 1'b0; in2_valid = 1'b0;

    // Test 2: both valid from reset, 2-beat bursts alternate with one bubble each
    reset = 1'b1; tick(); reset = 1'b0;
    in1_valid = 1'b1; in1 = 9'h0B1; in2_valid = 1'b1; in2 = 9'h0C1;
    tick();
    chk("t2_g1_sel", 16'(sel), 16'd0);
    chk("t2_g1_rdy2", 16'(in2_ready), 16'd0);
    tick(); chk_out("t2_b1", 9'h0B1, 1'b1, 1'b0);
    in1 = 9'h0B2; in1_last = 1'b1;
    tick(); chk_out("t2_b2", 9'h0B2, 1'b1, 1'b1);
    in1 = 9'h0B3; in1_last = 1'b0;
    tick(); chk("t2_bub1", 16'(out_valid), 16'd0);
    chk("t2_g2_sel", 16'(sel), 16'd1);
    chk("t2_g2_rdy1", 16'(in1_ready), 16'd0);
    tick(); chk_out("t2_c1", 9'h0C1, 1'b1, 1'b0);
    in2 = 9'h0C2; in2_last = 1'b1;
    tick(); chk_out("t2_c2", 9'h0C2, 1'b1, 1'b1);
    in2_valid = 1'b0; in2_last = 1'b0;
    tick(); chk("t2_bub2", 16'(out_valid), 16'd0);
    chk("t2_g3_sel", 16'(sel), 16'd0);
    tick(); chk_out("t2_b3", 9'h0B3, 1'b1, 1'b0);
    in1_valid = 1'b0;

    // Test 3: in2 streams 20 words without last; forced release at beat 16
    reset = 1'b1; tick(); reset = 1'b0;
    in2_valid = 1'b1; in2 = 9'h100;
    tick(); chk("t3_sel", 16'(sel), 16'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_out($sformatf("t3_w%0d", i), 9'(9'h100 + i), 1'b1, (i == 15));
      in2 = 9'(9'h100 + i + 1);
    end
    tick(); chk("t3_bubble", 16'(out_valid), 16'd0);
    chk("t3_regrant_sel", 16'(sel), 16'd1);
    for (int i = 16; i < 20; i++) begin
      tick();
      chk_out($sformatf("t3_w%0d", i), 9'(9'h100 + i), 1'b1, 1'b0);
      in2 = 9'(9'h100 + i + 1);
    end
    in2_valid = 1'b0;

    // Test 4: out_ready low 4 cycles mid-burst
    reset = 1'b1; tick(); reset = 1'b0;
    in1_valid = 1'b1; in1 = 9'h0D0;
    tick();
    tick(); chk_out("t4_d0", 9'h0D0, 1'b1, 1'b0);
    in1 = 9'h0D1;
    tick(); chk_out("t4_d1", 9'h0D1, 1'b1, 1'b0);
    in1 = 9'h0D2; out_ready = 1'b0; #1;
    chk("t4_stall_rdy", 16'(in1_ready), 16'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("t4_hold%0d", i), 9'h0D1, 1'b1, 1'b0);
      chk($sformatf("t4_hold%0d_rdy", i), 16'(in1_ready), 16'd0);
    end
    out_ready = 1'b1;
    tick(); chk_out("t4_d2", 9'h0D2, 1'b1, 1'b0);
    in1 = 9'h0D3;
    tick(); chk_out("t4_d3", 9'h0D3, 1'b1, 1'b0);
    in1 = 9'h0D4; in1_last = 1'b1;
    tick(); chk_out("t4_d4", 9'h0D4, 1'b1, 1'b1);
    in1 = 9'h0E0; in1_last = 1'b0;

    // Test 5: reset mid-burst with out_valid=1 (prio was 1 before reset)
    tick();
    tick(); chk_out("t5_e0", 9'h0E0, 1'b1, 1'b0);
    in1 = 9'h0E1; reset = 1'b1;
    tick(); reset = 1'b0;
    in2_valid = 1'b1; in2 = 9'h0F0; #1;
    chk_out("t5_rst", 9'h000, 1'b0, 1'b0);
    chk("t5_rst_sel", 16'(sel), 16'd0);
    chk("t5_rst_rdy1", 16'(in1_ready), 16'd0);
    chk("t5_rst_rdy2", 16'(in2_ready), 16'd0);
    tick();
    chk("t5_prio_sel", 16'(sel), 16'd0);
    chk("t5_prio_rdy1", 16'(in1_ready), 16'd1);
    chk("t5_prio_rdy2", 16'(in2_ready), 16'd0);
    in1_valid = 1'b0; in2_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
